// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
//  Module   : gray_counter
//  Purpose  : N-bit up/down counter with registered binary and Gray outputs,
//             binary or Gray-encoded parallel load, and a choice of wrapping
//             at the count limits (wrap pulse) or saturating there (sat level).
//  Revision : 1.0 - initial release
// ============================================================================
module gray_counter #(
  parameter int N    = 4,   // counter width, 2..32
  parameter int WRAP = 1    // 1: wrap at the limits, 0: saturate at the limits
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic         load_gray,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] bin_out,
  output logic [N-1:0] gray_out,
  output logic         wrap,
  output logic         sat
);

  localparam logic [N-1:0] c_MAX      = {N{1'b1}};
  localparam logic [N-1:0] c_ZERO     = {N{1'b0}};
  localparam logic [N-1:0] c_ONE      = {{(N-1){1'b0}}, 1'b1};
  localparam bit           c_SATURATE = (WRAP == 0);

  logic [N-1:0] b_q, b_d;
  logic [N-1:0] gray_q, gray_d;
  logic         wrap_q, wrap_d;
  logic         sat_q, sat_d;

  logic [N-1:0] w_load_bin;
  logic         w_at_limit;
  logic         w_load_at_limit;

  // Gray-to-binary conversion: each binary bit is the XOR of all Gray bits
  // at and above it, built from the MSB downward.
  function automatic logic [N-1:0] gray_to_bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Load operand decode and limit detection for the current direction.
  always_comb begin
    w_load_bin      = load_gray ? gray_to_bin(load_val) : load_val;
    w_at_limit      = up ? (b_q == c_MAX) : (b_q == c_ZERO);
    w_load_at_limit = up ? (w_load_bin == c_MAX) : (w_load_bin == c_ZERO);
  end

  // Next-state logic: load beats count enable; an idle cycle holds the count,
  // drops the wrap pulse and keeps sat only while still pinned in this direction.
  always_comb begin
    b_d    = b_q;
    wrap_d = 1'b0;
    sat_d  = 1'b0;
    if (load) begin
      b_d   = w_load_bin;
      sat_d = c_SATURATE && w_load_at_limit;
    end else if (en) begin
      if (!w_at_limit) begin
        b_d = up ? (b_q + c_ONE) : (b_q - c_ONE);
      end else if (c_SATURATE) begin
        sat_d = 1'b1;
      end else begin
        b_d    = up ? c_ZERO : c_MAX;
        wrap_d = 1'b1;
      end
    end else begin
      sat_d = sat_q && w_at_limit;
    end
    // Gray register is loaded from the same next value as the binary one,
    // so the two outputs can never disagree.
    gray_d = b_d ^ (b_d >> 1);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q    <= c_ZERO;
      gray_q <= c_ZERO;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      b_q    <= b_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign bin_out  = b_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;
  assign sat      = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gray_counter
//  Purpose  : Self-checking bench for gray_counter (N=4), one wrapping and one
//             saturating instance driven from shared stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gray_counter;

  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0] b;
    logic [N-1:0] g;
    logic         w;
    logic         s;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, en, up, load, load_gray;
  logic [N-1:0] load_val;
  logic [N-1:0] bin_w, gray_w, bin_s, gray_s;
  logic         wrap_w, sat_w, wrap_s, sat_s;

  int   n_checks;
  int   n_fail;
  exp_t m_w, m_s;
  exp_t q_w[$];
  exp_t q_s[$];

  logic [N-1:0] gseq [0:16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  always #5 clk = ~clk;

  gray_counter #(.N(N), .WRAP(1)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .load_val(load_val), .bin_out(bin_w), .gray_out(gray_w), .wrap(wrap_w), .sat(sat_w)
  );

  gray_counter #(.N(N), .WRAP(0)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .load_val(load_val), .bin_out(bin_s), .gray_out(gray_s), .wrap(wrap_s), .sat(sat_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: binary value whose Gray code equals the load word is
  // found by search rather than by the bitwise recurrence.
  function automatic exp_t model_next(input bit wmode, input exp_t cur);
    exp_t         nx;
    logic [N-1:0] lb;
    logic [N-1:0] cand;
    logic         lim;
    nx   = cur;
    nx.w = 1'b0;
    lim  = up ? (cur.b == 4'hF) : (cur.b == 4'h0);
    lb   = load_val;
    if (rst) begin
      nx.b = 4'h0;
      nx.s = 1'b0;
    end else if (load) begin
      if (load_gray) begin
        for (int v = 0; v < 16; v++) begin
          cand = 4'(v);
          if ((cand ^ (cand >> 1)) == load_val) lb = cand;
        end
      end
      nx.b = lb;
      nx.s = !wmode && (up ? (lb == 4'hF) : (lb == 4'h0));
    end else if (en) begin
      if (!lim) begin
        nx.b = up ? cur.b + 4'd1 : cur.b - 4'd1;
        nx.s = 1'b0;
      end else if (wmode) begin
        nx.b = up ? 4'h0 : 4'hF;
        nx.w = 1'b1;
        nx.s = 1'b0;
      end else begin
        nx.s = 1'b1;
      end
    end else begin
      nx.s = cur.s && lim;
    end
    nx.g = nx.b ^ (nx.b >> 1);
    return nx;
  endfunction

  // One clock of stimulus: predict, queue, clock, then pop and compare.
  task automatic step(input logic r, input logic e, input logic u, input logic l,
                      input logic lg, input logic [N-1:0] lv);
    logic [N-1:0] prev_g;
    logic [N-1:0] prev_b;
    exp_t         ew, es;
    rst       = r;
    en        = e;
    up        = u;
    load      = l;
    load_gray = lg;
    load_val  = lv;
    m_w = model_next(1'b1, m_w);
    m_s = model_next(1'b0, m_s);
    q_w.push_back(m_w);
    q_s.push_back(m_s);
    prev_g = gray_w;
    prev_b = bin_w;
    @(posedge clk);
    #1;
    ew = q_w.pop_front();
    es = q_s.pop_front();
    check("w.bin",  32'(bin_w),  32'(ew.b));
    check("w.gray", 32'(gray_w), 32'(ew.g));
    check("w.wrap", 32'(wrap_w), 32'(ew.w));
    check("w.sat",  32'(sat_w),  32'(ew.s));
    check("s.bin",  32'(bin_s),  32'(es.b));
    check("s.gray", 32'(gray_s), 32'(es.g));
    check("s.wrap", 32'(wrap_s), 32'(es.w));
    check("s.sat",  32'(sat_s),  32'(es.s));
    check("w.gray_eq_bin", 32'(gray_w), 32'(bin_w ^ (bin_w >> 1)));
    check("s.gray_eq_bin", 32'(gray_s), 32'(bin_s ^ (bin_s >> 1)));
    if (e && !l && !r && (prev_b !== bin_w))
      check("w.gray_1bit", 32'($countones(prev_g ^ gray_w)), 32'd1);
  endtask

  initial begin
    logic dir;
    n_checks = 0;
    n_fail   = 0;
    m_w      = '0;
    m_s      = '0;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_gray = 1'b0; load_val = '0;

    // Reset state
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    check("rst.bin",  32'(bin_w),  32'h0);
    check("rst.gray", 32'(gray_w), 32'h0);
    check("rst.wrap", 32'(wrap_w), 32'h0);
    check("rst.sat",  32'(sat_s),  32'h0);

    // Full up-count cycle with wrap
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
      check("seq.gray", 32'(gray_w), 32'(gseq[k]));
      check("seq.wrap", 32'(wrap_w), (k == 16) ? 32'd1 : 32'd0);
    end

    // Down-wrap from zero
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    check("dnwrap.bin",  32'(bin_w),  32'hF);
    check("dnwrap.gray", 32'(gray_w), 32'h8);
    check("dnwrap.wrap", 32'(wrap_w), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    check("dnwrap.pulse_end", 32'(wrap_w), 32'h0);

    // Gray-encoded loads
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0110);
    check("gload1.bin",  32'(bin_w),  32'h4);
    check("gload1.gray", 32'(gray_w), 32'h6);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0010);
    check("gload2.bin",  32'(bin_w),  32'h3);

    // Saturation at the top, then release by direction change
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1110);
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    check("sat.bin", 32'(bin_s), 32'hF);
    check("sat.lvl", 32'(sat_s), 32'h1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    check("satrel.bin", 32'(bin_s), 32'hE);
    check("satrel.lvl", 32'(sat_s), 32'h0);

    // Load onto the down limit sets sat; idle direction flip clears it
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    check("ldsat.lvl", 32'(sat_s), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    check("dirflip.lvl", 32'(sat_s), 32'h0);

    // Load beats enable; reset beats everything; count resumes from zero
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0101);
    check("ldpri.bin", 32'(bin_w), 32'h5);
    check("ldpri.bin_s", 32'(bin_s), 32'h5);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'hA);
    check("rstpri.bin",  32'(bin_w),  32'h0);
    check("rstpri.gray", 32'(gray_s), 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    check("resume.bin", 32'(bin_w), 32'h1);

    // Random mix, direction changes only occasionally so limits are reached
    dir = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, dir,
           $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter N, default 4: counter width in bits; legal range 2..32.
REQ-002 Parameter WRAP, default 1: 1 = wrap at the count limits; 0 = saturate at the count limits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  count enable; one step per cycle while high.
REQ-006 up  input  1  count direction; 1 = increment, 0 = decrement.
REQ-007 load  input  1  load strobe; captures load_val.
REQ-008 load_gray  input  1  encoding of load_val; 1 = Gray, 0 = binary.
REQ-009 load_val  input  N  load value.
REQ-010 bin_out  output  N  registered count, binary encoding.
REQ-011 gray_out  output  N  registered count, Gray encoding.
REQ-012 wrap  output  1  registered one-cycle pulse: the last update crossed a count limit (WRAP=1 only).
REQ-013 sat  output  1  registered level: the count is held at a limit (WRAP=0 only).

Function
REQ-014 The block SHALL hold one N-bit binary count register B; bin_out SHALL equal B.
REQ-015 gray_out SHALL be a register updated in the same edge as B, equal to next_B XOR (next_B >> 1); gray_out and bin_out SHALL never disagree in any cycle.
REQ-016 Priority per edge SHALL be rst > load > en; with none of these active, all state SHALL hold.
REQ-017 Load with load_gray=0 SHALL set B to load_val.
REQ-018 Load with load_gray=1 SHALL set B[N-1] to load_val[N-1], and for i = N-2 down to 0, B[i] to B[i+1] XOR load_val[i].
REQ-019 Load SHALL clear wrap and SHALL set sat only if the loaded value equals the limit in the current up direction and WRAP=0.
REQ-020 Count-step latency SHALL be one cycle: the value is visible on the edge after en is sampled high.
REQ-021 en=1, up=1, B < 2^N-1: B SHALL increment by 1.
REQ-022 en=1, up=0, B > 0: B SHALL decrement by 1.
REQ-023 At B = 2^N-1 with en=1 and up=1:
- WRAP=1: B SHALL become 0 and wrap SHALL be 1 for exactly one cycle.
- WRAP=0: B SHALL hold and sat SHALL be 1.
REQ-024 At B = 0 with en=1 and up=0:
- WRAP=1: B SHALL become 2^N-1 and wrap SHALL pulse.
- WRAP=0: B SHALL hold and sat SHALL be 1.
REQ-025 sat SHALL clear on the first edge where B leaves the limit, or where a direction change makes the step legal.
REQ-026 wrap SHALL be 0 on every cycle that does not follow a wrapping step; back-to-back wrapping steps (N small, en held) SHALL each pulse wrap.
REQ-027 sat SHALL be constant 0 when WRAP=1; wrap SHALL be constant 0 when WRAP=0.
REQ-028 Consecutive gray_out values across any single count step SHALL differ in exactly one bit, including the wrap step.
REQ-029 Arithmetic SHALL be modulo 2^N with no overflow beyond N bits.

Reset
REQ-030 rst=1 at an edge SHALL set bin_out=0, gray_out=0, wrap=0 and sat=0, regardless of en and load.
REQ-031 Reset asserted mid-count SHALL take effect on the next edge; counting SHALL resume from 0 on the first edge with rst=0 and en=1.

Verification (N=4)
REQ-032 Reset, then en=1, up=1 for 16 cycles -> gray_out sequence 0000,0001,0011,0010,0110,…,1000,0000; wrap=1 only in the cycle B returns to 0.
REQ-033 load=1, load_gray=1, load_val=0110 -> bin_out=0100, gray_out=0110. Then load_val=0010 -> bin_out=0011.
REQ-034 WRAP=1, B=0, en=1, up=0 -> bin_out=1111, gray_out=1000, wrap pulses once.
REQ-035 WRAP=0, load binary 1110, en=1, up=1 for 3 cycles -> bin_out 1111 then holds, sat=1. Then up=0 -> bin_out=1110, sat=0.
REQ-036 load=1 and en=1 on the same edge with load_val=0101 (binary) -> bin_out=0101, no step applied. Then rst=1 with en=1 and load=1 -> all outputs 0.
REQ-037 A bench self-check SHALL confirm, on every cycle of all scenarios, that gray_out equals bin_out XOR (bin_out >> 1).
